alu_muldiv: RTL
===============

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values even, 8..64.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 3, operation code width (funct3 encoding).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of in-flight operation.
REQ-006 SHALL have port in_valid  input  1  operands/Operation valid.
REQ-007 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-008 SHALL have ports SrcA, SrcB  input  DATA_WIDTH  operands.
REQ-009 SHALL have port Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port ALUResult  output  DATA_WIDTH  result.
REQ-013 SHALL have port DivByZero  output  1  result came from a divide/remainder with SrcB==0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE).
REQ-015 SHALL accept on rising edge with state IDLE and in_valid=1, capturing SrcA, SrcB, Operation; inputs ignored otherwise.
REQ-016 SHALL perform one radix-2 iteration per CALC cycle (shift-add multiply, restoring divide on magnitudes), exactly DATA_WIDTH iterations.
REQ-017 SHALL assert out_valid DATA_WIDTH+1 edges after the accepting edge (CALC iterations then DONE) for all non-special operations.
REQ-018 SHALL hold out_valid, ALUResult, DivByZero stable in DONE until out_ready=1; on that edge return to IDLE.
REQ-019 SHALL NOT accept a new operation on the same edge a result is consumed (one-cycle IDLE gap).
REQ-020 MUL SHALL return low DATA_WIDTH bits of product; MULH/MULHSU/MULHU high DATA_WIDTH bits of signed x signed / signed x unsigned / unsigned x unsigned 2*DATA_WIDTH-bit product.
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign equals dividend sign.
REQ-022 Divide-by-zero (op 1xx, SrcB==0) SHALL skip CALC, enter DONE on the edge after acceptance: quotient all-ones, remainder = SrcA, DivByZero=1.
REQ-023 Signed overflow (DIV/REM, SrcA = most-negative, SrcB = all-ones) SHALL skip CALC: DIV result = SrcA, REM result = 0, DivByZero=0.
REQ-024 flush=1 SHALL force state IDLE on that edge from any state, discarding results; out_valid low next cycle; flush has priority over acceptance.
REQ-025 ALUResult SHALL be 0 and DivByZero 0 whenever out_valid=0.

Reset
REQ-026 reset low SHALL immediately force state IDLE, iteration counter 0, internal registers 0, out_valid 0, ALUResult 0, DivByZero 0; in_ready 1 after release.
REQ-027 Reset asserted mid-CALC SHALL discard the operation; no result produced after release.

Configuration
REQ-028 Macro ALU_MULDIV_DIV_EN SHALL, when defined, include division hardware per REQ-016..REQ-023.
REQ-029 Without ALU_MULDIV_DIV_EN, ops 1xx SHALL skip CALC, enter DONE on the edge after acceptance with ALUResult 0, DivByZero 0; multiply unchanged; no divider logic synthesised.

Verification
REQ-030 MUL 7 x -3 (DATA_WIDTH=32) -> out_valid exactly 33 cycles after accept, ALUResult 0xFFFFFFEB.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIV 5/0 -> 0xFFFFFFFF, DivByZero=1, out_valid 1 cycle after accept; REM 0x80000000/0xFFFFFFFF -> 0, DivByZero=0.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready 0; raise out_ready -> IDLE, in_ready 1 next cycle.
REQ-035 flush at CALC iteration 10, and reset low at iteration 20 of a second op -> out_valid never asserts; next op completes correctly.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative RISC-V M-extension multiply/divide unit.
//
// Each operation is captured once and then processed one bit per clock
// (radix-2). Multiplies use shift-add, divides use restoring division.
// Both work on operand magnitudes, and a final cycle applies the sign.
// An operation is accepted in IDLE. Iterations run in CALC. The result is
// held in DONE until the consumer takes it.
//
// Latency: an ordinary operation shows out_valid DATA_WIDTH+1 edges after
// the accepting edge. That is DATA_WIDTH iterations plus one sign-fix cycle.
// Special cases do no iterations: they show out_valid one edge after
// acceptance. The special cases are divide-by-zero, signed overflow and,
// with division disabled, every divide op.
//
// Build option: define ALU_MULDIV_DIV_EN to include the divider. When it is
// undefined, ops 1xx return 0 with DivByZero=0 and no divider is built.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous abort; has priority over acceptance
//   in_valid   SrcA/SrcB/Operation valid
//   in_ready   unit idle and able to accept
//   SrcA, SrcB operands
//   Operation  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result
//   ALUResult  result; zero whenever out_valid is low
//   DivByZero  result came from a divide/remainder by zero
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     DivByZero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [2:0]      op_reg;
  logic [W-1:0]    p_hi;        // product high half / partial remainder
  logic [W-1:0]    p_lo;        // multiplier->product low / dividend->quotient
  logic [W-1:0]    mcand;       // multiplicand or divisor magnitude
  logic            neg_reg;     // final result must be negated
  logic            special_reg; // p_lo already holds the final result
  logic            dbz_pend;
  logic [W-1:0]    result_reg;

  // ---------------- operand decode at acceptance ----------------
  logic [2:0]   op_in;
  logic         accept;
  logic         a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [W-1:0] a_mag, b_mag;
  logic         special_in, dbz_in;
  logic [W-1:0] special_val;

  assign op_in    = Operation[2:0];
  assign accept   = (state == IDLE) && in_valid && !flush;
  assign a_signed = (op_in == 3'b001) || (op_in == 3'b010) ||
                    (op_in == 3'b100) || (op_in == 3'b110);
  assign b_signed = (op_in == 3'b001) || (op_in == 3'b100) || (op_in == 3'b110);
  assign a_neg    = a_signed && SrcA[W-1];
  assign b_neg    = b_signed && SrcB[W-1];
  assign a_mag    = a_neg ? ('0 - SrcA) : SrcA;
  assign b_mag    = b_neg ? ('0 - SrcB) : SrcB;
  // Remainder takes the dividend's sign; everything else takes the sign of a xor b.
  assign neg_in   = (op_in[2] && op_in[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef ALU_MULDIV_DIV_EN
  logic b_zero, ovf;
  assign b_zero      = (SrcB == '0);
  // Most-negative / -1 on signed ops only (funct3 bit 0 clear).
  assign ovf         = !op_in[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
  assign special_in  = op_in[2] && (b_zero || ovf);
  assign dbz_in      = op_in[2] && b_zero;
  assign special_val = b_zero ? (op_in[1] ? SrcA : '1)
                              : (op_in[1] ? '0   : SrcA);
`else
  assign special_in  = op_in[2];
  assign dbz_in      = 1'b0;
  assign special_val = '0;
`endif

  // ---------------- one radix-2 step ----------------
  logic [W:0]   mul_sum;
  logic [W-1:0] step_hi, step_lo;

  assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);

`ifdef ALU_MULDIV_DIV_EN
  logic [W:0]   div_shift;
  logic [W+1:0] div_diff;
  logic         div_ok;
  assign div_shift = {p_hi, p_lo[W-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mcand};
  assign div_ok    = !div_diff[W+1];   // no borrow: divisor fits
  always_comb begin
    step_hi = mul_sum[W:1];
    step_lo = {mul_sum[0], p_lo[W-1:1]};
    if (op_reg[2]) begin
      step_hi = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
      step_lo = {p_lo[W-2:0], div_ok};
    end
  end
`else
  assign step_hi = mul_sum[W:1];
  assign step_lo = {mul_sum[0], p_lo[W-1:1]};
`endif

  // ---------------- sign fix / result select ----------------
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   mul_res, div_res, final_res;

  assign prod     = {p_hi, p_lo};
  assign prod_fix = neg_reg ? ('0 - prod) : prod;
  assign mul_res  = (op_reg[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];

`ifdef ALU_MULDIV_DIV_EN
  assign div_res  = op_reg[1] ? (neg_reg ? ('0 - p_hi) : p_hi)
                              : (neg_reg ? ('0 - p_lo) : p_lo);
`else
  assign div_res  = '0;
`endif

  assign final_res = special_reg ? p_lo : (op_reg[2] ? div_res : mul_res);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (count == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      op_reg      <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      mcand       <= '0;
      neg_reg     <= 1'b0;
      special_reg <= 1'b0;
      dbz_pend    <= 1'b0;
      result_reg  <= '0;
    end else if (flush) begin
      count      <= '0;
      result_reg <= '0;
      dbz_pend   <= 1'b0;
    end else if (accept) begin
      op_reg      <= op_in;
      p_hi        <= '0;
      p_lo        <= special_in ? special_val : (op_in[2] ? a_mag : b_mag);
      mcand       <= op_in[2] ? b_mag : a_mag;
      neg_reg     <= neg_in;
      special_reg <= special_in;
      dbz_pend    <= dbz_in;
      // Special cases jump straight to the final cycle.
      count       <= special_in ? LAST : '0;
    end else if (state == CALC) begin
      if (count == LAST) begin
        result_reg <= final_res;
      end else begin
        p_hi  <= step_hi;
        p_lo  <= step_lo;
        count <= count + 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      count      <= '0;
      result_reg <= '0;
      dbz_pend   <= 1'b0;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign ALUResult = out_valid ? result_reg : '0;
  assign DivByZero = out_valid && dbz_pend;

endmodule
